// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared widths, entry type and pointer helper for the writeback queue
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 16;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int wb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fwd_lookup.sv
// ============================================================================
// Module   : wb_fwd_lookup
// Brief    : Youngest-match search over queued writes plus the output register
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_fwd_lookup
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int PTR_W  = wb_ptr_w(WB_DEPTH)
) (
    input  logic [ADDR_W-1:0]             lookupAddress_i,
    input  logic [DEPTH-1:0]              entryValid_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  entryAddr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]  entryData_i,
    input  logic [PTR_W-1:0]              headPtr_i,
    input  logic                          outValid_i,
    input  logic [ADDR_W-1:0]             outAddr_i,
    input  logic [DATA_W-1:0]             outData_i,
    output logic                          hit_o,
    output logic [DATA_W-1:0]             data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest-to-youngest so each later match overrides; the output
    // register is older than every queued entry and is considered first.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (outValid_i && (outAddr_i == lookupAddress_i)) begin
            hit_o  = 1'b1;
            data_o = outData_i;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr_i + PTR_W'(k);
            if (entryValid_i[idx] && (entryAddr_i[idx] == lookupAddress_i)) begin
                hit_o  = 1'b1;
                data_o = entryData_i[idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_queue.sv
// ============================================================================
// Module   : wb_queue
// Brief    : Dual-lane writeback queue draining one write per cycle to the RF
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic               clock_i,
    input  logic               nReset_i,
    input  logic               wbEnableA_i,
    input  logic [ADDR_W-1:0]  wbAddressA_i,
    input  logic [DATA_W-1:0]  wbDataA_i,
    input  logic               wbEnableB_i,
    input  logic [ADDR_W-1:0]  wbAddressB_i,
    input  logic [DATA_W-1:0]  wbDataB_i,
    output logic               stall_o,
    output logic               overflow_o,
    output logic               rfWrEnable_o,
    output logic [ADDR_W-1:0]  rfWrAddress_o,
    output logic [DATA_W-1:0]  rfWrData_o,
    input  logic [ADDR_W-1:0]  lookupAddressA_i,
    output logic               fwdHitA_o,
    output logic [DATA_W-1:0]  fwdDataA_o,
    input  logic [ADDR_W-1:0]  lookupAddressB_i,
    output logic               fwdHitB_o,
    output logic [DATA_W-1:0]  fwdDataB_o
);

    localparam int PTR_W = wb_ptr_w(DEPTH);

    logic [PTR_W:0]                count_q, count_d;
    logic [PTR_W-1:0]              rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]              wrPtr_q, wrPtr_d;
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
    logic                          overflow_q, overflow_d;
    logic                          rfWrEnable_q, rfWrEnable_d;
    logic [ADDR_W-1:0]             rfWrAddress_q, rfWrAddress_d;
    logic [DATA_W-1:0]             rfWrData_q, rfWrData_d;

    logic                          stall;
    logic                          pushA;
    logic                          pushB;
    logic                          pop;
    logic [PTR_W:0]                numPush;
    logic [PTR_W-1:0]              slotB;

    // Stalling at DEPTH-1 guarantees two free slots whenever pushes are accepted.
    assign stall   = (count_q >= (PTR_W+1)'(DEPTH - 1));
    assign pushA   = !stall && wbEnableA_i &&
                     !(wbEnableB_i && (wbAddressA_i == wbAddressB_i));
    assign pushB   = !stall && wbEnableB_i;
    assign pop     = (count_q != '0);
    assign numPush = (PTR_W+1)'(pushA) + (PTR_W+1)'(pushB);

    always_comb begin
        count_d       = count_q;
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        valid_d       = valid_q;
        addr_d        = addr_q;
        data_d        = data_q;
        overflow_d    = overflow_q;
        rfWrEnable_d  = 1'b0;
        rfWrAddress_d = rfWrAddress_q;
        rfWrData_d    = rfWrData_q;
        slotB         = wrPtr_q;

        if (pop) begin
            rfWrEnable_d     = 1'b1;
            rfWrAddress_d    = addr_q[rdPtr_q];
            rfWrData_d       = data_q[rdPtr_q];
            valid_d[rdPtr_q] = 1'b0;
            rdPtr_d          = rdPtr_q + PTR_W'(1);
        end

        if (pushA) begin
            addr_d[wrPtr_q]  = wbAddressA_i;
            data_d[wrPtr_q]  = wbDataA_i;
            valid_d[wrPtr_q] = 1'b1;
            slotB            = wrPtr_q + PTR_W'(1);
        end
        if (pushB) begin
            addr_d[slotB]  = wbAddressB_i;
            data_d[slotB]  = wbDataB_i;
            valid_d[slotB] = 1'b1;
        end

        wrPtr_d = wrPtr_q + numPush[PTR_W-1:0];
        count_d = count_q + numPush - (PTR_W+1)'(pop);

        if (stall && (wbEnableA_i || wbEnableB_i)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge nReset_i) begin
        if (!nReset_i) begin
            count_q       <= '0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            valid_q       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            overflow_q    <= 1'b0;
            rfWrEnable_q  <= 1'b0;
            rfWrAddress_q <= '0;
            rfWrData_q    <= '0;
        end else begin
            count_q       <= count_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            valid_q       <= valid_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            overflow_q    <= overflow_d;
            rfWrEnable_q  <= rfWrEnable_d;
            rfWrAddress_q <= rfWrAddress_d;
            rfWrData_q    <= rfWrData_d;
        end
    end

    assign stall_o       = stall;
    assign overflow_o    = overflow_q;
    assign rfWrEnable_o  = rfWrEnable_q;
    assign rfWrAddress_o = rfWrAddress_q;
    assign rfWrData_o    = rfWrData_q;

    wb_fwd_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwdA (
        .lookupAddress_i (lookupAddressA_i),
        .entryValid_i    (valid_q),
        .entryAddr_i     (addr_q),
        .entryData_i     (data_q),
        .headPtr_i       (rdPtr_q),
        .outValid_i      (rfWrEnable_q),
        .outAddr_i       (rfWrAddress_q),
        .outData_i       (rfWrData_q),
        .hit_o           (fwdHitA_o),
        .data_o          (fwdDataA_o)
    );

    wb_fwd_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwdB (
        .lookupAddress_i (lookupAddressB_i),
        .entryValid_i    (valid_q),
        .entryAddr_i     (addr_q),
        .entryData_i     (data_q),
        .headPtr_i       (rdPtr_q),
        .outValid_i      (rfWrEnable_q),
        .outAddr_i       (rfWrAddress_q),
        .outData_i       (rfWrData_q),
        .hit_o           (fwdHitB_o),
        .data_o          (fwdDataB_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
// ============================================================================
// Module   : tb_wb_queue
// Brief    : Directed and randomized bench for wb_queue against a queue model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = WB_ADDR_W;
    localparam int DW    = WB_DATA_W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wbEnableA_i, wbEnableB_i;
    logic [AW-1:0]  wbAddressA_i, wbAddressB_i;
    logic [DW-1:0]  wbDataA_i, wbDataB_i;
    logic           stall_o, overflow_o, rfWrEnable_o;
    logic [AW-1:0]  rfWrAddress_o;
    logic [DW-1:0]  rfWrData_o;
    logic [AW-1:0]  lookupAddressA_i, lookupAddressB_i;
    logic           fwdHitA_o, fwdHitB_o;
    logic [DW-1:0]  fwdDataA_o, fwdDataB_o;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock_i          (clk),
        .nReset_i         (rst_n),
        .wbEnableA_i      (wbEnableA_i),
        .wbAddressA_i     (wbAddressA_i),
        .wbDataA_i        (wbDataA_i),
        .wbEnableB_i      (wbEnableB_i),
        .wbAddressB_i     (wbAddressB_i),
        .wbDataB_i        (wbDataB_i),
        .stall_o          (stall_o),
        .overflow_o       (overflow_o),
        .rfWrEnable_o     (rfWrEnable_o),
        .rfWrAddress_o    (rfWrAddress_o),
        .rfWrData_o       (rfWrData_o),
        .lookupAddressA_i (lookupAddressA_i),
        .fwdHitA_o        (fwdHitA_o),
        .fwdDataA_o       (fwdDataA_o),
        .lookupAddressB_i (lookupAddressB_i),
        .fwdHitB_o        (fwdHitB_o),
        .fwdDataB_o       (fwdDataB_o)
    );

    // Reference state: pending writes in age order plus the RF output register.
    wb_entry_t      mq[$];
    bit             mOutEn;
    logic [AW-1:0]  mOutAddr;
    logic [DW-1:0]  mOutData;
    bit             mOvf;
    int             nCmp;
    int             nFail;
    int             wrSeen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_fwd(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == a) begin
                hit = 1'b1;
                d   = mq[i].data;
                return;
            end
        end
        if (mOutEn && (mOutAddr == a)) begin
            hit = 1'b1;
            d   = mOutData;
        end
    endtask

    task automatic check_all();
        bit            h;
        logic [DW-1:0] d;
        check("stall",    32'(stall_o),       32'(mq.size() >= DEPTH - 1));
        check("overflow", 32'(overflow_o),    32'(mOvf));
        check("rfWrEn",   32'(rfWrEnable_o),  32'(mOutEn));
        check("rfWrAddr", 32'(rfWrAddress_o), 32'(mOutAddr));
        check("rfWrData", 32'(rfWrData_o),    32'(mOutData));
        model_fwd(lookupAddressA_i, h, d);
        check("fwdHitA",  32'(fwdHitA_o),     32'(h));
        check("fwdDataA", 32'(fwdDataA_o),    32'(d));
        model_fwd(lookupAddressB_i, h, d);
        check("fwdHitB",  32'(fwdHitB_o),     32'(h));
        check("fwdDataB", 32'(fwdDataB_o),    32'(d));
    endtask

    task automatic step(input bit ea, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input bit eb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        wb_entry_t e;
        bit        full;
        wbEnableA_i  = ea;
        wbAddressA_i = aa;
        wbDataA_i    = da;
        wbEnableB_i  = eb;
        wbAddressB_i = ab;
        wbDataB_i    = db;
        @(posedge clk);
        full = (mq.size() >= DEPTH - 1);
        if (mq.size() > 0) begin
            e        = mq.pop_front();
            mOutEn   = 1'b1;
            mOutAddr = e.addr;
            mOutData = e.data;
        end else begin
            mOutEn = 1'b0;
        end
        if (!full) begin
            if (ea && !(eb && (aa == ab))) mq.push_back('{addr: aa, data: da});
            if (eb)                        mq.push_back('{addr: ab, data: db});
        end else if (ea || eb) begin
            mOvf = 1'b1;
        end
        #1;
        lookupAddressA_i = AW'($urandom_range(0, 7));
        lookupAddressB_i = AW'($urandom_range(0, 7));
        #1;
        check_all();
        if (rfWrEnable_o) wrSeen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic lookup(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input bit ha, input logic [DW-1:0] da,
                          input bit hb, input logic [DW-1:0] db);
        lookupAddressA_i = a;
        lookupAddressB_i = b;
        #1;
        check({tag, "_hitA"},  32'(fwdHitA_o),  32'(ha));
        check({tag, "_dataA"}, 32'(fwdDataA_o), 32'(da));
        check({tag, "_hitB"},  32'(fwdHitB_o),  32'(hb));
        check({tag, "_dataB"}, 32'(fwdDataB_o), 32'(db));
    endtask

    task automatic random_phase(input int n);
        bit ea, eb;
        for (int i = 0; i < n; i++) begin
            ea = 1'($urandom_range(0, 1));
            eb = 1'($urandom_range(0, 1));
            if (mq.size() >= DEPTH - 1) begin
                ea = 1'b0;
                eb = 1'b0;
            end
            step(ea, AW'($urandom_range(0, 7)), DW'($urandom),
                 eb, AW'($urandom_range(0, 7)), DW'($urandom));
        end
    endtask

    initial begin
        nCmp = 0; nFail = 0; wrSeen = 0;
        mOutEn = 1'b0; mOutAddr = '0; mOutData = '0; mOvf = 1'b0;
        rst_n = 1'b0;
        wbEnableA_i = 1'b0; wbAddressA_i = '0; wbDataA_i = '0;
        wbEnableB_i = 1'b0; wbAddressB_i = '0; wbDataB_i = '0;
        lookupAddressA_i = '0; lookupAddressB_i = '0;
        #2;
        check_all();
        #10;
        rst_n = 1'b1;

        // Single write: visible on the RF port one cycle after the following edge.
        step(1'b1, 5'd3, 16'h1234, 1'b0, '0, '0);
        check("single_en0", 32'(rfWrEnable_o), 32'd0);
        idle(1);
        check("single_en",   32'(rfWrEnable_o),  32'd1);
        check("single_addr", 32'(rfWrAddress_o), 32'd3);
        check("single_data", 32'(rfWrData_o),    32'h1234);
        idle(1);
        check("single_done", 32'(rfWrEnable_o),  32'd0);

        // Dual write retires A then B.
        step(1'b1, 5'd5, 16'hAAAA, 1'b1, 5'd6, 16'hBBBB);
        idle(1);
        check("dual_a_addr", 32'(rfWrAddress_o), 32'd5);
        check("dual_a_data", 32'(rfWrData_o),    32'hAAAA);
        idle(1);
        check("dual_b_en",   32'(rfWrEnable_o),  32'd1);
        check("dual_b_addr", 32'(rfWrAddress_o), 32'd6);
        check("dual_b_data", 32'(rfWrData_o),    32'hBBBB);
        idle(1);
        check("dual_done",   32'(rfWrEnable_o),  32'd0);

        // Same-address collision keeps only the younger lane.
        step(1'b1, 5'd7, 16'h1111, 1'b1, 5'd7, 16'h2222);
        idle(1);
        check("coll_addr", 32'(rfWrAddress_o), 32'd7);
        check("coll_data", 32'(rfWrData_o),    32'h2222);
        idle(1);
        check("coll_done", 32'(rfWrEnable_o),  32'd0);

        // Forwarding from the queue, then from the output register.
        step(1'b1, 5'd9, 16'h0001, 1'b0, '0, '0);
        step(1'b1, 5'd9, 16'h0002, 1'b0, '0, '0);
        lookup("fwd_q", 5'd9, 5'd10, 1'b1, 16'h0002, 1'b0, 16'h0000);
        idle(1);
        lookup("fwd_out", 5'd9, 5'd10, 1'b1, 16'h0002, 1'b0, 16'h0000);
        idle(2);

        random_phase(150);
        idle(5);

        // Fill to the stall threshold, then push into the stall.
        wrSeen = 0;
        step(1'b1, 5'd1, 16'h0101, 1'b1, 5'd2, 16'h0202);
        check("fill_stall0", 32'(stall_o), 32'd0);
        step(1'b1, 5'd3, 16'h0303, 1'b1, 5'd4, 16'h0404);
        check("fill_stall1", 32'(stall_o), 32'd1);
        step(1'b1, 5'd5, 16'h0505, 1'b1, 5'd6, 16'h0606);
        check("fill_ovf", 32'(overflow_o), 32'd1);
        idle(5);
        check("fill_writes", 32'(wrSeen), 32'd4);
        check("ovf_sticky",  32'(overflow_o), 32'd1);

        // Reset mid-stream with two writes pending.
        step(1'b1, 5'd11, 16'hBEEF, 1'b1, 5'd12, 16'hCAFE);
        rst_n = 1'b0;
        lookupAddressA_i = 5'd11;
        lookupAddressB_i = 5'd12;
        #1;
        mq.delete();
        mOutEn = 1'b0; mOutAddr = '0; mOutData = '0; mOvf = 1'b0;
        check_all();
        #2;
        rst_n = 1'b1;
        wrSeen = 0;
        idle(4);
        check("rst_no_writes", 32'(wrSeen), 32'd0);

        random_phase(100);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

`default_nettype wire
